// File: rtl/flash_pkg.sv
// Shared definitions for the flash program/erase controller.
// Holds the FSM state encoding, the flash command words and the status-register
// bit positions, plus a helper that classifies a status byte as failed.
// Optional feature macro: FLASH_PROG_CTRL_ERASE_EN (adds ERS_SETUP/ERS_CONF states).
package flash_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PRG_SETUP = 4'd1,
    PRG_DATA  = 4'd2,
`ifdef FLASH_PROG_CTRL_ERASE_EN
    ERS_SETUP = 4'd3,
    ERS_CONF  = 4'd4,
`endif
    STS_CMD   = 4'd5,
    STS_READ  = 4'd6,
    CLR_STS   = 4'd7,
    RD_ARRAY  = 4'd8,
    DONE      = 4'd9
  } state_e;

  localparam logic [15:0] CMD_PROGRAM      = 16'h0040;
  localparam logic [15:0] CMD_ERASE_SETUP  = 16'h0020;
  localparam logic [15:0] CMD_ERASE_CONF   = 16'h00D0;
  localparam logic [15:0] CMD_READ_STATUS  = 16'h0070;
  localparam logic [15:0] CMD_CLEAR_STATUS = 16'h0050;
  localparam logic [15:0] CMD_READ_ARRAY   = 16'h00FF;

  localparam int unsigned STS_READY     = 7;
  localparam int unsigned STS_ERASE_ERR = 5;
  localparam int unsigned STS_PROG_ERR  = 4;
  localparam int unsigned STS_VPP_ERR   = 3;
  localparam int unsigned STS_LOCK_ERR  = 1;

  function automatic logic sts_has_error(input logic [7:0] sts);
    return sts[STS_ERASE_ERR] | sts[STS_PROG_ERR] | sts[STS_VPP_ERR] | sts[STS_LOCK_ERR];
  endfunction

endpackage

// File: rtl/flash_bus_access.sv
// Single-access engine for the downstream flash bus.
// A start pulse while idle launches one read or write; the strobe, address and
// data are held from flops until the first cycle with fl_stall low, which is the
// completing cycle (ack high, rdata valid). start is ignored while an access is
// in flight, so the caller may hold it high for the whole command state.
// Ports:
//   clk_bus, rst          clock, async active-high reset
//   start, is_write       launch request and direction
//   addr, data            access address / write data
//   ack, rdata            completion strobe and read data (combinational)
//   fl_*                  downstream flash bus
module flash_bus_access (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic        start,
  input  logic        is_write,
  input  logic [23:0] addr,
  input  logic [31:0] data,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [23:0] fl_address,
  output logic [31:0] fl_data_o,
  output logic        fl_read,
  output logic        fl_write,
  input  logic [31:0] fl_data_i,
  input  logic        fl_stall
);

  logic        active_q, active_d;
  logic        write_q, write_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    active_d = active_q;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (!active_q && start) begin
      active_d = 1'b1;
      write_d  = is_write;
      addr_d   = addr;
      data_d   = is_write ? data : 32'h0;
    end else if (active_q && !fl_stall) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      active_q <= active_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign ack        = active_q && !fl_stall;
  assign rdata      = fl_data_i;
  assign fl_read    = active_q && !write_q;
  assign fl_write   = active_q && write_q;
  assign fl_address = addr_q;
  assign fl_data_o  = data_q;

endmodule

// File: rtl/flash_prog_ctrl.sv
// Flash program/erase sequencer.
// Accepts a one-word program (or, when built with FLASH_PROG_CTRL_ERASE_EN, a
// block erase), issues the command sequence over the downstream bus, polls the
// status register until ready or until POLL_LIMIT reads, clears status on
// failure and always leaves the device in read-array mode.
// Ports:
//   clk_bus, rst                   clock, async active-high reset
//   cmd_program, cmd_erase         requests, sampled only in IDLE
//   cmd_addr, cmd_data             target address / program data
//   busy, done, error, status      progress and result
//   fl_address, fl_data_o, fl_data_i, fl_read, fl_write, fl_stall  downstream bus
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for a request
// PRG_SETUP | write program-setup command 0x40
// PRG_DATA  | write the latched data word
// ERS_SETUP | write erase-setup command 0x20 (erase build only)
// ERS_CONF  | write erase-confirm command 0xD0 (erase build only)
// STS_CMD   | write read-status command 0x70, arm poll counter
// STS_READ  | read status until ready, device error or poll timeout
// CLR_STS   | write clear-status command 0x50 after a failure
// RD_ARRAY  | write read-array command 0xFF
// DONE      | one-cycle done pulse, result valid
module flash_prog_ctrl
  import flash_pkg::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'd4096
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic        cmd_program,
  input  logic        cmd_erase,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status,
  output logic [23:0] fl_address,
  output logic [31:0] fl_data_o,
  input  logic [31:0] fl_data_i,
  output logic        fl_read,
  output logic        fl_write,
  input  logic        fl_stall
);

  state_e      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  status_q, status_d;
  logic        error_q, error_d;
  logic [15:0] poll_q, poll_d;

  logic        acc_start, acc_write, acc_ack;
  logic [31:0] acc_data, acc_rdata;
  logic [7:0]  sts_rd;
  logic        unused_rdata;

  assign sts_rd       = acc_rdata[7:0];
  assign unused_rdata = ^acc_rdata[31:8];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    status_d  = status_q;
    error_d   = error_q;
    poll_d    = poll_q;
    acc_start = 1'b0;
    acc_write = 1'b1;
    acc_data  = 32'h0;
    case (state_q)
      IDLE: begin
`ifdef FLASH_PROG_CTRL_ERASE_EN
        if (cmd_erase) begin
          addr_d  = cmd_addr;
          error_d = 1'b0;
          state_d = ERS_SETUP;
        end else if (cmd_program) begin
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          error_d = 1'b0;
          state_d = PRG_SETUP;
        end
`else
        if (cmd_program) begin
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          error_d = 1'b0;
          state_d = PRG_SETUP;
        end else if (cmd_erase) begin
          // Erase not built: reject immediately without touching the bus.
          error_d  = 1'b1;
          status_d = 8'h00;
          state_d  = DONE;
        end
`endif
      end
      PRG_SETUP: begin
        acc_start = 1'b1;
        acc_data  = {16'h0, CMD_PROGRAM};
        if (acc_ack) state_d = PRG_DATA;
      end
      PRG_DATA: begin
        acc_start = 1'b1;
        acc_data  = {16'h0, data_q};
        if (acc_ack) state_d = STS_CMD;
      end
`ifdef FLASH_PROG_CTRL_ERASE_EN
      ERS_SETUP: begin
        acc_start = 1'b1;
        acc_data  = {16'h0, CMD_ERASE_SETUP};
        if (acc_ack) state_d = ERS_CONF;
      end
      ERS_CONF: begin
        acc_start = 1'b1;
        acc_data  = {16'h0, CMD_ERASE_CONF};
        if (acc_ack) state_d = STS_CMD;
      end
`endif
      STS_CMD: begin
        acc_start = 1'b1;
        acc_data  = {16'h0, CMD_READ_STATUS};
        poll_d    = POLL_LIMIT;
        if (acc_ack) state_d = STS_READ;
      end
      STS_READ: begin
        acc_start = 1'b1;
        acc_write = 1'b0;
        if (acc_ack) begin
          status_d = sts_rd;
          if (!sts_rd[STS_READY]) begin
            // Down-counter reaches terminal count on the POLL_LIMIT-th busy read.
            if (poll_q <= 16'd1) begin
              error_d  = 1'b1;
              status_d = 8'hFF;
              state_d  = CLR_STS;
            end else begin
              poll_d = poll_q - 16'd1;
            end
          end else if (sts_has_error(sts_rd)) begin
            error_d = 1'b1;
            state_d = CLR_STS;
          end else begin
            state_d = RD_ARRAY;
          end
        end
      end
      CLR_STS: begin
        acc_start = 1'b1;
        acc_data  = {16'h0, CMD_CLEAR_STATUS};
        if (acc_ack) state_d = RD_ARRAY;
      end
      RD_ARRAY: begin
        acc_start = 1'b1;
        acc_data  = {16'h0, CMD_READ_ARRAY};
        if (acc_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      status_q <= 8'h00;
      error_q  <= 1'b0;
      poll_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      status_q <= status_d;
      error_q  <= error_d;
      poll_q   <= poll_d;
    end
  end

  flash_bus_access u_bus (
    .clk_bus    (clk_bus),
    .rst        (rst),
    .start      (acc_start),
    .is_write   (acc_write),
    .addr       (addr_q),
    .data       (acc_data),
    .ack        (acc_ack),
    .rdata      (acc_rdata),
    .fl_address (fl_address),
    .fl_data_o  (fl_data_o),
    .fl_read    (fl_read),
    .fl_write   (fl_write),
    .fl_data_i  (fl_data_i),
    .fl_stall   (fl_stall)
  );

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign error  = error_q;
  assign status = status_q;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed bench for flash_prog_ctrl with a stalling flash stub and a scoreboard
// of expected downstream accesses.
module tb_flash_prog_ctrl;

  logic        clk_bus = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_program = 1'b0;
  logic        cmd_erase = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        busy, done, error;
  logic [7:0]  status;
  logic [23:0] fl_address;
  logic [31:0] fl_data_o;
  logic [31:0] fl_data_i;
  logic        fl_read, fl_write, fl_stall;

  flash_prog_ctrl #(.POLL_LIMIT(16'd4)) dut (
    .clk_bus(clk_bus), .rst(rst), .cmd_program(cmd_program), .cmd_erase(cmd_erase),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done), .error(error),
    .status(status), .fl_address(fl_address), .fl_data_o(fl_data_o), .fl_data_i(fl_data_i),
    .fl_read(fl_read), .fl_write(fl_write), .fl_stall(fl_stall)
  );

  initial forever #5 clk_bus = ~clk_bus;

  // Flash stub: each access stalls stall_cycles cycles; reads return a status table.
  int          stall_cycles = 0;
  int          stall_cnt = 0;
  int          rd_cnt = 0;
  int          rd_base = 0;
  int          sts_n = 1;
  logic [7:0]  sts_tab [16];

  assign fl_stall = (fl_read || fl_write) && (stall_cnt < stall_cycles);

  always @(posedge clk_bus) begin
    if (!(fl_read || fl_write)) stall_cnt <= 0;
    else if (fl_stall) stall_cnt <= stall_cnt + 1;
    if (fl_read && !fl_stall) rd_cnt <= rd_cnt + 1;
  end

  always_comb begin
    int idx;
    idx = rd_cnt - rd_base;
    if (idx >= sts_n) idx = sts_n - 1;
    if (idx < 0) idx = 0;
    fl_data_i = {24'h0, sts_tab[idx]};
  end

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [31:0] data;
  } acc_t;
  acc_t sb[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic exp_acc(input logic wr, input logic [23:0] a, input logic [15:0] d);
    acc_t e;
    e.wr = wr; e.addr = a; e.data = {16'h0, d};
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and check any bus activity against the scoreboard.
  task automatic tick();
    @(negedge clk_bus);
    if (fl_read || fl_write) begin
      chk("rw_exclusive", {31'h0, fl_read & fl_write}, 32'h0);
      if (sb.size() == 0) begin
        chk("unexpected_access", {8'h0, fl_address}, 32'hFFFF_FFFF);
      end else begin
        chk("acc_dir", {31'h0, fl_write}, {31'h0, sb[0].wr});
        chk("acc_addr", {8'h0, fl_address}, {8'h0, sb[0].addr});
        if (sb[0].wr) chk("acc_data", fl_data_o, sb[0].data);
        if (!fl_stall) void'(sb.pop_front());
      end
    end
  endtask

  task automatic set_sts(input logic [7:0] a, input logic [7:0] b, input int n);
    sts_tab[0] = a; sts_tab[1] = b; sts_n = n;
    rd_base = rd_cnt;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      tick();
      if (done) break;
    end
    if (k == 300) chk({tag, "_done_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic finish_op(input string tag, input logic e, input logic [7:0] s);
    chk({tag, "_error"}, {31'h0, error}, {31'h0, e});
    chk({tag, "_status"}, {24'h0, status}, {24'h0, s});
    chk({tag, "_sb_empty"}, sb.size(), 32'h0);
    tick();
    chk({tag, "_done_low"}, {31'h0, done}, 32'h0);
    chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic launch_program(input string tag, input logic [23:0] a, input logic [15:0] d);
    cmd_addr = a; cmd_data = d; cmd_program = 1'b1;
    tick();
    cmd_program = 1'b0;
    chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
    chk({tag, "_error_cleared"}, {31'h0, error}, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_error"}, {31'h0, error}, 32'h0);
    chk({tag, "_status"}, {24'h0, status}, 32'h0);
    chk({tag, "_fl_read"}, {31'h0, fl_read}, 32'h0);
    chk({tag, "_fl_write"}, {31'h0, fl_write}, 32'h0);
    chk({tag, "_fl_address"}, {8'h0, fl_address}, 32'h0);
    chk({tag, "_fl_data_o"}, fl_data_o, 32'h0);
  endtask

  initial begin
    int k;
    set_sts(8'h80, 8'h80, 1);

    // Reset values
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Program with 3-cycle stalls, ready on second status read; a request
    // during busy must be ignored (scoreboard holds the original address).
    stall_cycles = 3;
    set_sts(8'h00, 8'h80, 2);
    exp_acc(1, 24'h000100, 16'h0040);
    exp_acc(1, 24'h000100, 16'hA5A5);
    exp_acc(1, 24'h000100, 16'h0070);
    exp_acc(0, 24'h000100, 16'h0000);
    exp_acc(0, 24'h000100, 16'h0000);
    exp_acc(1, 24'h000100, 16'h00FF);
    launch_program("prog", 24'h000100, 16'hA5A5);
    cmd_addr = 24'hFFFFFF; cmd_data = 16'hDEAD; cmd_program = 1'b1; cmd_erase = 1'b1;
    tick();
    cmd_program = 1'b0; cmd_erase = 1'b0;
    wait_done("prog");
    finish_op("prog", 1'b0, 8'h80);

    // Device error status 0x90
    stall_cycles = 0;
    set_sts(8'h90, 8'h90, 1);
    exp_acc(1, 24'h001234, 16'h0040);
    exp_acc(1, 24'h001234, 16'h1234);
    exp_acc(1, 24'h001234, 16'h0070);
    exp_acc(0, 24'h001234, 16'h0000);
    exp_acc(1, 24'h001234, 16'h0050);
    exp_acc(1, 24'h001234, 16'h00FF);
    launch_program("deverr", 24'h001234, 16'h1234);
    wait_done("deverr");
    finish_op("deverr", 1'b1, 8'h90);

    // Poll timeout: status stuck at 0x00, limit 4
    stall_cycles = 1;
    set_sts(8'h00, 8'h00, 1);
    exp_acc(1, 24'hABCDEF, 16'h0040);
    exp_acc(1, 24'hABCDEF, 16'h7E57);
    exp_acc(1, 24'hABCDEF, 16'h0070);
    for (int i = 0; i < 4; i++) exp_acc(0, 24'hABCDEF, 16'h0000);
    exp_acc(1, 24'hABCDEF, 16'h0050);
    exp_acc(1, 24'hABCDEF, 16'h00FF);
    launch_program("timeout", 24'hABCDEF, 16'h7E57);
    wait_done("timeout");
    finish_op("timeout", 1'b1, 8'hFF);

`ifdef FLASH_PROG_CTRL_ERASE_EN
    // Erase has priority over a simultaneous program
    stall_cycles = 0;
    set_sts(8'h80, 8'h80, 1);
    exp_acc(1, 24'h020000, 16'h0020);
    exp_acc(1, 24'h020000, 16'h00D0);
    exp_acc(1, 24'h020000, 16'h0070);
    exp_acc(0, 24'h020000, 16'h0000);
    exp_acc(1, 24'h020000, 16'h00FF);
    cmd_addr = 24'h020000; cmd_data = 16'h1111; cmd_erase = 1'b1; cmd_program = 1'b1;
    tick();
    cmd_erase = 1'b0; cmd_program = 1'b0;
    chk("erase_busy", {31'h0, busy}, 32'h1);
    wait_done("erase");
    finish_op("erase", 1'b0, 8'h80);
`else
    // Erase not built: immediate done with error, no bus traffic
    cmd_addr = 24'h020000; cmd_erase = 1'b1;
    tick();
    cmd_erase = 1'b0;
    chk("erase_dis_done", {31'h0, done}, 32'h1);
    finish_op("erase_dis", 1'b1, 8'h00);
`endif

    // Reset during the stalled PRG_DATA write
    stall_cycles = 6;
    exp_acc(1, 24'h000200, 16'h0040);
    exp_acc(1, 24'h000200, 16'h5A5A);
    launch_program("rstmid", 24'h000200, 16'h5A5A);
    for (k = 0; k < 60; k++) begin
      tick();
      if (fl_write && fl_data_o == 32'h0000_5A5A) break;
    end
    if (k == 60) chk("rstmid_reach_prg_data", 32'h0, 32'h1);
    tick();
    chk("rstmid_stalled", {31'h0, fl_stall}, 32'h1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rstmid_async");
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_busy_next", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("rstmid_no_traffic", {31'h0, fl_read | fl_write}, 32'h0);
    chk("rstmid_still_idle", {31'h0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
